ysyx_25050148_lsu: RTL and testbench

Load/store unit sitting between the single-cycle core's execute stage and the `ysyx_25050148_mem` data-memory model, acting as the initiator on the memory's read/write port. It accepts one load or store request at a time over a valid/ready handshake, checks alignment and func3 legality, and drives the memory strobes for exactly one cycle after a programmable access latency. It then returns load data (already extended by the memory per func3) or a store completion over a valid/ready response channel.

---
 rtl/ysyx_25050148_lsu.sv | 134 +++++++++++++
 tb/tb_ysyx_25050148_lsu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25050148_lsu.sv
// Load/store unit: one request at a time, single-cycle memory strobe
// after a fixed access latency, response held until consumed.
module ysyx_25050148_lsu #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read_valid,
    output logic        mem_write_valid,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [2:0]  mem_func3,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        is_store_q;
    logic [2:0]  func3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic accept, legal, f3_ok, align_ok, fire, busy, resp_hs;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign fire      = (state == WAIT) && (cnt == 4'd0);
    assign busy      = (state != IDLE);
    assign resp_hs   = (state == RESP) & resp_ready;

    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        if (req_is_store)
            f3_ok = req_func3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = req_func3 inside {3'b000, 3'b001, 3'b010,
                                      3'b100, 3'b101, 3'b110};
        if (req_func3[1:0] == 2'b01)
            align_ok = ~req_addr[0];
        else if (req_func3[1:0] == 2'b10)
            align_ok = (req_addr[1:0] == 2'b00);
        legal = f3_ok & align_ok;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = legal ? WAIT : RESP;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            is_store_q <= 1'b0;
            func3_q    <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                is_store_q <= req_is_store;
                func3_q    <= req_func3;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                err_q      <= ~legal;
                cnt        <= legal ? CNT_INIT : 4'd0;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && !is_store_q)
                rdata_q <= mem_rdata;
            if (resp_hs) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Strobes come straight from state so an async reset kills them at once
    assign mem_read_valid  = fire & ~is_store_q;
    assign mem_write_valid = fire & is_store_q;
    assign mem_wen         = mem_write_valid;
    assign mem_raddr       = busy ? addr_q  : 32'd0;
    assign mem_waddr       = busy ? addr_q  : 32'd0;
    assign mem_func3       = busy ? func3_q : 3'd0;
    assign mem_wdata       = busy ? wdata_q : 32'd0;

    always_comb begin
        mem_wmask = 4'b0000;
        if (busy && is_store_q) begin
            unique case (func3_q)
                3'b000:  mem_wmask = 4'b0001;
                3'b001:  mem_wmask = 4'b0011;
                3'b010:  mem_wmask = 4'b1111;
                default: mem_wmask = 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25050148_lsu.sv
// Directed bench for the LSU: two instances, latency 1 and latency 4,
// each attached to a small combinational memory model.
module tb_ysyx_25050148_lsu;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_is_store;
    logic [2:0]  a_req_func3;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_resp_rdata;
    logic        a_mem_read_valid, a_mem_write_valid, a_mem_wen;
    logic [31:0] a_mem_raddr, a_mem_waddr, a_mem_wdata, a_mem_rdata;
    logic [2:0]  a_mem_func3;
    logic [3:0]  a_mem_wmask;

    logic        b_req_valid, b_req_ready, b_req_is_store;
    logic [2:0]  b_req_func3;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_resp_rdata;
    logic        b_mem_read_valid, b_mem_write_valid, b_mem_wen;
    logic [31:0] b_mem_raddr, b_mem_waddr, b_mem_wdata, b_mem_rdata;
    logic [2:0]  b_mem_func3;
    logic [3:0]  b_mem_wmask;

    // Memory model: one fixed word, everything else reads as ~address
    assign a_mem_rdata = (a_mem_raddr == 32'h80000004) ? 32'hDEADBEEF : ~a_mem_raddr;
    assign b_mem_rdata = ~b_mem_raddr;

    ysyx_25050148_lsu #(.LATENCY(1)) u_lsu_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_is_store(a_req_is_store), .req_func3(a_req_func3),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_read_valid(a_mem_read_valid), .mem_write_valid(a_mem_write_valid),
        .mem_wen(a_mem_wen), .mem_raddr(a_mem_raddr), .mem_waddr(a_mem_waddr),
        .mem_func3(a_mem_func3), .mem_wmask(a_mem_wmask),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    ysyx_25050148_lsu #(.LATENCY(4)) u_lsu_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_is_store(b_req_is_store), .req_func3(b_req_func3),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_read_valid(b_mem_read_valid), .mem_write_valid(b_mem_write_valid),
        .mem_wen(b_mem_wen), .mem_raddr(b_mem_raddr), .mem_waddr(b_mem_waddr),
        .mem_func3(b_mem_func3), .mem_wmask(b_mem_wmask),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_rd_cnt = 0, a_wr_cnt = 0, b_rd_cnt = 0, b_wr_cnt = 0;
    int          a_acc_q[$];
    logic [31:0] a_rsp_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_mem_read_valid)  a_rd_cnt <= a_rd_cnt + 1;
        if (a_mem_write_valid) a_wr_cnt <= a_wr_cnt + 1;
        if (b_mem_read_valid)  b_rd_cnt <= b_rd_cnt + 1;
        if (b_mem_write_valid) b_wr_cnt <= b_wr_cnt + 1;
        if (a_req_valid && a_req_ready) a_acc_q.push_back(cyc);
        if (a_resp_valid && a_resp_ready) a_rsp_q.push_back(a_resp_rdata);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic st, input logic [2:0] f3,
                         input logic [31:0] ad, input logic [31:0] wd);
        a_req_valid    = 1'b1;
        a_req_is_store = st;
        a_req_func3    = f3;
        a_req_addr     = ad;
        a_req_wdata    = wd;
    endtask

    int n, w0, r0, rb0;

    initial begin
        rst_n = 1'b0;
        a_req_valid = 0; a_req_is_store = 0; a_req_func3 = 0;
        a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 1;
        b_req_valid = 0; b_req_is_store = 0; b_req_func3 = 0;
        b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 0;

        #3;
        check("rst_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst_raddr", a_mem_raddr, 32'd0);
        check("rst_b_ready", 32'(b_req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // lw, latency 1
        a_req(1'b0, 3'b010, 32'h80000004, 32'd0);
        tick();
        a_req_valid = 1'b0;
        check("lw_rv_c1", 32'(a_mem_read_valid), 32'd1);
        check("lw_wv_c1", 32'(a_mem_write_valid), 32'd0);
        check("lw_raddr", a_mem_raddr, 32'h80000004);
        check("lw_func3", 32'(a_mem_func3), 32'd2);
        check("lw_wmask", 32'(a_mem_wmask), 32'd0);
        check("lw_ready_c1", 32'(a_req_ready), 32'd0);
        tick();
        check("lw_rv_c2", 32'(a_mem_read_valid), 32'd0);
        check("lw_resp_valid", 32'(a_resp_valid), 32'd1);
        check("lw_rdata", a_resp_rdata, 32'hDEADBEEF);
        check("lw_err", 32'(a_resp_err), 32'd0);
        tick();
        check("lw_idle_ready", 32'(a_req_ready), 32'd1);
        check("lw_idle_rdata", a_resp_rdata, 32'd0);
        check("lw_idle_raddr", a_mem_raddr, 32'd0);

        // sh
        w0 = a_wr_cnt;
        a_req(1'b1, 3'b001, 32'h80000002, 32'h1234ABCD);
        tick();
        a_req_valid = 1'b0;
        check("sh_wv", 32'(a_mem_write_valid), 32'd1);
        check("sh_wen", 32'(a_mem_wen), 32'd1);
        check("sh_rv", 32'(a_mem_read_valid), 32'd0);
        check("sh_wmask", 32'(a_mem_wmask), 32'h3);
        check("sh_waddr", a_mem_waddr, 32'h80000002);
        check("sh_wdata", a_mem_wdata, 32'h1234ABCD);
        tick();
        check("sh_wv_c2", 32'(a_mem_write_valid), 32'd0);
        check("sh_resp_valid", 32'(a_resp_valid), 32'd1);
        check("sh_rdata", a_resp_rdata, 32'd0);
        check("sh_err", 32'(a_resp_err), 32'd0);
        tick();
        check("sh_wr_count", 32'(a_wr_cnt - w0), 32'd1);

        // misaligned lw and illegal store func3
        w0 = a_wr_cnt; r0 = a_rd_cnt;
        a_req(1'b0, 3'b010, 32'h80000001, 32'd0);
        tick();
        a_req_valid = 1'b0;
        check("lwmis_resp_valid", 32'(a_resp_valid), 32'd1);
        check("lwmis_err", 32'(a_resp_err), 32'd1);
        check("lwmis_rdata", a_resp_rdata, 32'd0);
        check("lwmis_rv", 32'(a_mem_read_valid), 32'd0);
        tick();
        check("lwmis_err_clr", 32'(a_resp_err), 32'd0);
        a_req(1'b1, 3'b011, 32'h80000000, 32'h55);
        tick();
        a_req_valid = 1'b0;
        check("sbbad_resp_valid", 32'(a_resp_valid), 32'd1);
        check("sbbad_err", 32'(a_resp_err), 32'd1);
        check("sbbad_wv", 32'(a_mem_write_valid), 32'd0);
        tick();
        tick();
        check("err_no_rd", 32'(a_rd_cnt - r0), 32'd0);
        check("err_no_wr", 32'(a_wr_cnt - w0), 32'd0);

        // back-to-back loads with req_valid held
        r0 = a_rd_cnt;
        a_acc_q.delete();
        a_rsp_q.delete();
        for (int i = 0; i < 3; i++) begin
            a_req(1'b0, 3'b010, 32'h100 + 32'(4 * i), 32'd0);
            n = 0;
            while (!a_req_ready && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) check("b2b_timeout", 32'(n), 32'd0);
            tick();
        end
        a_req_valid = 1'b0;
        repeat (4) tick();
        check("b2b_strobes", 32'(a_rd_cnt - r0), 32'd3);
        check("b2b_acc_n", 32'(a_acc_q.size()), 32'd3);
        check("b2b_rsp_n", 32'(a_rsp_q.size()), 32'd3);
        if (a_acc_q.size() == 3) begin
            check("b2b_gap0", 32'(a_acc_q[1] - a_acc_q[0]), 32'd3);
            check("b2b_gap1", 32'(a_acc_q[2] - a_acc_q[1]), 32'd3);
        end
        if (a_rsp_q.size() == 3) begin
            check("b2b_rsp0", a_rsp_q[0], 32'hFFFFFEFF);
            check("b2b_rsp1", a_rsp_q[1], 32'hFFFFFEFB);
            check("b2b_rsp2", a_rsp_q[2], 32'hFFFFFEF7);
        end

        // lb at latency 4 with a stalled consumer
        rb0 = b_rd_cnt;
        b_req_valid = 1'b1; b_req_is_store = 1'b0;
        b_req_func3 = 3'b000; b_req_addr = 32'h80000010;
        tick();
        b_req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("lb_rv_c%0d", k), 32'(b_mem_read_valid), 32'(k == 4));
            check($sformatf("lb_ready_c%0d", k), 32'(b_req_ready), 32'd0);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            check("lb_hold_valid", 32'(b_resp_valid), 32'd1);
            check("lb_hold_rdata", b_resp_rdata, 32'h7FFFFFEF);
            check("lb_hold_err", 32'(b_resp_err), 32'd0);
            check("lb_hold_ready", 32'(b_req_ready), 32'd0);
            check("lb_hold_rv", 32'(b_mem_read_valid), 32'd0);
            tick();
        end
        b_resp_ready = 1'b1;
        check("lb_hs_valid", 32'(b_resp_valid), 32'd1);
        tick();
        b_resp_ready = 1'b0;
        check("lb_post_valid", 32'(b_resp_valid), 32'd0);
        check("lb_post_ready", 32'(b_req_ready), 32'd1);
        check("lb_post_rdata", b_resp_rdata, 32'd0);
        check("lb_rd_count", 32'(b_rd_cnt - rb0), 32'd1);

        // reset during WAIT of a store
        w0 = b_wr_cnt;
        b_req_valid = 1'b1; b_req_is_store = 1'b1;
        b_req_func3 = 3'b010; b_req_addr = 32'h80000020;
        b_req_wdata = 32'hCAFEF00D;
        tick();
        b_req_valid = 1'b0;
        check("rstw_waddr", b_mem_waddr, 32'h80000020);
        check("rstw_wv", 32'(b_mem_write_valid), 32'd0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rstw_ready", 32'(b_req_ready), 32'd1);
        check("rstw_wv_low", 32'(b_mem_write_valid), 32'd0);
        check("rstw_waddr0", b_mem_waddr, 32'd0);
        check("rstw_wdata0", b_mem_wdata, 32'd0);
        check("rstw_wmask0", 32'(b_mem_wmask), 32'd0);
        check("rstw_resp0", 32'(b_resp_valid), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("rstw_no_write", 32'(b_wr_cnt - w0), 32'd0);
        check("rstw_ready_after", 32'(b_req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
